// File: rtl/dmem_pkg.sv
// Shared FSM encoding, latency bounds and helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 15;
  localparam int CNT_WIDTH   = 4;

  // A word access must be word-aligned; a halfword access must be halfword-aligned.
  function automatic logic is_misaligned(input logic [1:0] lo, input logic [3:0] be);
    return ((be == 4'b1111) && (lo != 2'b00)) ||
           (((be == 4'b0011) || (be == 4'b1100)) && lo[0]);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage request/response bundle between the core and the data-memory responder.
// Defining DMEM_MISALIGN_TRAP_EN adds the misalign flag to the bundle.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        stall;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        misalign;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata, stall, misalign
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata, stall, misalign
  );
`else
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata, stall
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata, stall
  );
`endif
endinterface

// File: rtl/dmem_array.sv
// Single-port 2**ADDR_WIDTH x 32 word store with per-byte writes and a registered read.
module dmem_array #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];
  logic [31:0] rdata_q, rdata_d;

  // Contents survive reset; only a write landing on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (en && we && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) rdata_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Latency-programmable data-memory responder that stalls the MEM stage until each access completes.
// Defining DMEM_MISALIGN_TRAP_EN suppresses misaligned stores and reports them on misalign.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("dmem_responder: LATENCY must lie in 1..15");
  end

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           be_q, be_d;
  logic                 accept;
  logic                 mem_en, mem_we;
  logic [31:0]          mem_rdata;
  logic                 unused_addr_bits;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  // The *_d request fields double as the array operands, so LATENCY=1 can act on the accepting edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          be_d    = bus.req_be;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            cnt_d   = CNT_WIDTH'(LATENCY - 2);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_WIDTH'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == RESP);
    bus.stall      = accept || (state_q == WAIT);
    bus.resp_rdata = mem_rdata;
    mem_en         = (state_d == RESP);
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  always_comb misalign_d = mem_en && is_misaligned(addr_d[1:0], be_d);

  always_ff @(posedge clk) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end

  assign mem_we       = we_d && !misalign_d;
  assign bus.misalign = misalign_q;
`else
  assign mem_we = we_d;
`endif

  // Bits outside the word index only matter to the misalign check, if at all.
  assign unused_addr_bits = ^{addr_d[31:ADDR_WIDTH+2], addr_d[1:0]};

  dmem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk   (clk),
    .reset (reset),
    .en    (mem_en),
    .we    (mem_we),
    .be    (be_d),
    .addr  (addr_d[ADDR_WIDTH+1:2]),
    .wdata (wdata_d),
    .rdata (mem_rdata)
  );

endmodule
